// File: rtl/bus_pkg.sv
// bus_pkg: shared types and constants for the memory bus arbiter.
package bus_pkg;
    typedef enum logic [1:0] {REG_ROM, REG_RAM, REG_IO} region_t;
    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} arb_state_t;
    localparam logic [1:0] REQ_FETCH = 2'd0;
    localparam logic [1:0] REQ_DATA = 2'd1;
    localparam logic [1:0] REQ_DMA = 2'd2;
    localparam logic [15:0] RAM_BASE = 16'h4000;
    localparam logic [15:0] IO_BASE = 16'hC000;
    localparam logic [1:0] IO_NONE = 2'd0;
    localparam logic [1:0] IO_READ = 2'd1;
    localparam logic [1:0] IO_WRITE = 2'd2;
    function automatic region_t region_of(input logic [15:0] a);
        return a >= IO_BASE ? REG_IO : a >= RAM_BASE ? REG_RAM : REG_ROM;
    endfunction
endpackage

// File: rtl/rr_arbiter3.sv
// rr_arbiter3: combinational 3-way round-robin grant starting after last.
module rr_arbiter3 (
    input  logic [2:0] valid,
    input  logic [1:0] last,
    output logic [2:0] grant,
    output logic       any
);
    logic [1:0] p0, p1, p2;
    always_comb begin
        p0 = last >= 2'd2 ? 2'd0 : last + 2'd1;
        p1 = p0 == 2'd2 ? 2'd0 : p0 + 2'd1;
        p2 = p1 == 2'd2 ? 2'd0 : p1 + 2'd1;
        grant = valid[p0] ? 3'b001 << p0 :
                valid[p1] ? 3'b001 << p1 :
                valid[p2] ? 3'b001 << p2 : 3'b000;
        any = |valid;
    end
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin sharing of the 8/16-bit memory bus between
// fetch, data and dma requesters with region decode and wait states.
module mem_bus_arbiter
    import bus_pkg::*;
#(
    parameter int unsigned ROM_WAIT = 0,
    parameter int unsigned RAM_WAIT = 0,
    parameter int unsigned IO_WAIT  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  req_valid,
    input  logic [2:0]  req_write,
    input  logic [47:0] req_addr,
    input  logic [23:0] req_wdata,
    output logic [2:0]  req_ready,
    output logic [2:0]  rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        rsp_err,
    output logic [15:0] address,
    output logic        read,
    output logic        write,
    output logic [7:0]  dataOut,
    input  logic [7:0]  dataIn,
    output logic        cs_rom,
    output logic        cs_ram,
    output logic        cs_io
);
    arb_state_t state;
    logic [1:0] last, gnt, gidx, sel_op;
    logic [2:0] grant, cnt;
    logic       any, wr, rom_wr, sel_write;
    logic [15:0] sel_addr;
    logic [7:0] sel_wdata;
    region_t    sel_region;

    function automatic logic [2:0] wait_of(input region_t r);
        return r == REG_ROM ? 3'(ROM_WAIT) : r == REG_RAM ? 3'(RAM_WAIT) : 3'(IO_WAIT);
    endfunction

    rr_arbiter3 u_arb (.valid(req_valid), .last(last), .grant(grant), .any(any));

    always_comb begin
        gidx = grant[REQ_DMA] ? REQ_DMA : grant[REQ_DATA] ? REQ_DATA : REQ_FETCH;
        sel_addr = req_addr[16*gidx +: 16];
        sel_wdata = req_wdata[8*gidx +: 8];
        sel_write = req_write[gidx];
        sel_region = region_of(sel_addr);
        // ROM writes run the access timing but never reach the bus
        sel_op = !sel_write ? IO_READ : sel_region == REG_ROM ? IO_NONE : IO_WRITE;
    end

    assign req_ready = state == ST_IDLE ? grant : 3'b000;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            last <= 2'd2;
            gnt <= 2'd0;
            cnt <= 3'd0;
            wr <= 1'b0;
            rom_wr <= 1'b0;
            address <= 16'h0;
            read <= 1'b0;
            write <= 1'b0;
            dataOut <= 8'h0;
            cs_rom <= 1'b0;
            cs_ram <= 1'b0;
            cs_io <= 1'b0;
            rsp_valid <= 3'b000;
            rsp_rdata <= 8'h0;
            rsp_err <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (any) begin
                    state <= ST_ACCESS;
                    last <= gidx;
                    gnt <= gidx;
                    cnt <= wait_of(sel_region);
                    wr <= sel_write;
                    rom_wr <= sel_op == IO_NONE;
                    address <= sel_addr;
                    read <= sel_op == IO_READ;
                    write <= sel_op == IO_WRITE;
                    dataOut <= sel_op == IO_WRITE ? sel_wdata : 8'h0;
                    cs_rom <= sel_region == REG_ROM && sel_op != IO_NONE;
                    cs_ram <= sel_region == REG_RAM;
                    cs_io <= sel_region == REG_IO;
                end
                ST_ACCESS: if (cnt == 3'd0) begin
                    state <= ST_RESP;
                    rsp_valid <= 3'b001 << gnt;
                    rsp_rdata <= wr ? 8'h0 : dataIn;
                    rsp_err <= rom_wr;
                    address <= 16'h0;
                    read <= 1'b0;
                    write <= 1'b0;
                    dataOut <= 8'h0;
                    cs_rom <= 1'b0;
                    cs_ram <= 1'b0;
                    cs_io <= 1'b0;
                end else begin
                    cnt <= cnt - 3'd1;
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                    rsp_valid <= 3'b000;
                    rsp_err <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed vector table plus round-robin and
// mid-access reset sequences against hand-computed expectations.
module tb_mem_bus_arbiter;
    logic        clk = 1'b0, reset = 1'b1;
    logic [2:0]  req_valid = '0, req_write = '0;
    logic [47:0] req_addr = '0;
    logic [23:0] req_wdata = '0;
    logic [7:0]  dataIn = '0;
    logic [2:0]  req_ready, rsp_valid;
    logic [7:0]  rsp_rdata, dataOut;
    logic        rsp_err, read, write, cs_rom, cs_ram, cs_io;
    logic [15:0] address;
    int n_chk = 0, n_fail = 0;

    typedef struct {
        int         i;
        logic       wr;
        logic [15:0] a;
        logic [7:0] wd;
        logic [7:0] din;
        int         w;
        logic [2:0] cs;
        logic [7:0] rd;
        logic       err;
    } vec_t;
    vec_t v[9];

    mem_bus_arbiter dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .address(address), .read(read), .write(write), .dataOut(dataOut),
        .dataIn(dataIn), .cs_rom(cs_rom), .cs_ram(cs_ram), .cs_io(cs_io)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic bus_idle(input string nm);
        chk({nm, "_bus"}, {address, read, write, cs_io, cs_ram, cs_rom}, 0);
    endtask

    // Starts at a negedge with the DUT idle; ends at a negedge with the DUT idle.
    task automatic txn(input vec_t t);
        req_valid = 3'(1 << t.i);
        req_write[t.i] = t.wr;
        req_addr[16*t.i +: 16] = t.a;
        req_wdata[8*t.i +: 8] = t.wd;
        #1 chk("ready", {29'd0, req_ready}, 32'(1 << t.i));
        @(posedge clk);
        #1;
        req_valid = 3'b000;
        req_addr = '1;
        req_wdata = '1;
        req_write = '1;
        for (int k = 0; k <= t.w; k++) begin
            dataIn = k == t.w ? t.din : ~t.din;
            @(negedge clk);
            chk("access_addr", {16'd0, address}, {16'd0, t.a});
            chk("access_rw", {30'd0, read, write}, {30'd0, !t.wr, t.wr && !t.err});
            chk("access_cs", {29'd0, cs_io, cs_ram, cs_rom}, {29'd0, t.cs});
            if (t.wr && !t.err) chk("access_dout", {24'd0, dataOut}, {24'd0, t.wd});
            chk("access_rsp", {29'd0, rsp_valid}, 0);
            chk("access_ready", {29'd0, req_ready}, 0);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("rsp_valid", {29'd0, rsp_valid}, 32'(1 << t.i));
        chk("rsp_rdata", {24'd0, rsp_rdata}, {24'd0, t.rd});
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, t.err});
        bus_idle("resp");
        @(negedge clk);
        chk("rsp_drop", {29'd0, rsp_valid}, 0);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        req_valid = '0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic [2:0] rr[4];
        rr = '{3'b001, 3'b010, 3'b100, 3'b001};
        v[0] = '{0, 1'b0, 16'h0010, 8'h00, 8'hE0, 0, 3'b001, 8'hE0, 1'b0};
        v[1] = '{1, 1'b1, 16'h4100, 8'h5A, 8'hFF, 0, 3'b010, 8'h00, 1'b0};
        v[2] = '{2, 1'b0, 16'hC003, 8'h00, 8'h3C, 2, 3'b100, 8'h3C, 1'b0};
        v[3] = '{0, 1'b1, 16'h0005, 8'h66, 8'hFF, 0, 3'b000, 8'h00, 1'b1};
        v[4] = '{1, 1'b0, 16'hBFFF, 8'h00, 8'h77, 0, 3'b010, 8'h77, 1'b0};
        v[5] = '{2, 1'b1, 16'hFFFF, 8'hA5, 8'h12, 2, 3'b100, 8'h00, 1'b0};
        v[6] = '{0, 1'b0, 16'h3FFF, 8'h00, 8'h11, 0, 3'b001, 8'h11, 1'b0};
        v[7] = '{1, 1'b0, 16'h8000, 8'h00, 8'h99, 0, 3'b010, 8'h99, 1'b0};
        v[8] = '{2, 1'b0, 16'h7FFF, 8'h00, 8'h42, 0, 3'b010, 8'h42, 1'b0};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_rsp", {rsp_valid, rsp_rdata, rsp_err, req_ready, dataOut}, 0);
        bus_idle("reset");
        reset = 1'b0;
        @(negedge clk);
        chk("idle_ready", {29'd0, req_ready}, 0);

        for (int k = 0; k < 9; k++) txn(v[k]);

        // all three requesting continuously: 0,1,2,0 every third cycle
        pulse_reset();
        req_write = '0;
        req_addr = {16'h0300, 16'h0200, 16'h0100};
        dataIn = 8'h5D;
        req_valid = 3'b111;
        for (int k = 0; k < 4; k++) begin
            #1 chk("rr_grant", {29'd0, req_ready}, {29'd0, rr[k]});
            @(negedge clk);
            chk("rr_busy", {29'd0, req_ready}, 0);
            chk("rr_addr", {16'd0, address}, rr[k] == 3'b001 ? 32'h100 : rr[k] == 3'b010 ? 32'h200 : 32'h300);
            @(negedge clk);
            chk("rr_rsp", {29'd0, rsp_valid}, {29'd0, rr[k]});
            chk("rr_rdata", {24'd0, rsp_rdata}, 32'h5D);
            if (k == 3) req_valid = 3'b000;
            @(negedge clk);
        end
        repeat (2) begin
            chk("no_req_ready", {29'd0, req_ready}, 0);
            chk("no_req_bus", {31'd0, read}, 0);
            @(negedge clk);
        end

        // reset during the second IO access cycle of requester 1
        pulse_reset();
        req_addr = {16'h0030, 16'hC003, 16'h0010};
        req_valid = 3'b010;
        #1 chk("rst_grant", {29'd0, req_ready}, 32'b010);
        @(negedge clk);
        chk("rst_acc1", {30'd0, read, cs_io}, 32'b11);
        req_valid = 3'b000;
        @(negedge clk);
        chk("rst_acc2", {30'd0, read, cs_io}, 32'b11);
        reset = 1'b1;
        #1;
        bus_idle("rst_async");
        chk("rst_async_rsp", {29'd0, rsp_valid}, 0);
        @(negedge clk);
        chk("rst_held_rsp", {29'd0, rsp_valid}, 0);
        reset = 1'b0;
        dataIn = 8'hC7;
        req_valid = 3'b111;
        #1 chk("rst_first", {29'd0, req_ready}, 32'b001);
        @(negedge clk);
        chk("rst_after_rsp", {29'd0, rsp_valid}, 0);
        chk("rst_after_addr", {16'd0, address}, 32'h0010);
        @(negedge clk);
        chk("rst_after_resp", {29'd0, rsp_valid}, 32'b001);
        chk("rst_after_rdata", {24'd0, rsp_rdata}, 32'hC7);
        req_valid = 3'b000;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single 8-bit-data, 16-bit-address memory bus between three requesters: CPU instruction fetch, CPU operand/data port, and a DMA/video port.
- Arbitrates round-robin and decodes the address into ROM/RAM/IO chip selects.
- Inserts per-region wait states and returns read data with a one-cycle response strobe.
- Sits between the Cpu core ports and the ROM/RAM/IO devices on the top-level bus.

Parameters:
- ROM_WAIT, 0, extra ACCESS cycles for region ROM (0x0000-0x3FFF); range 0-7.
- RAM_WAIT, 0, extra ACCESS cycles for region RAM (0x4000-0xBFFF); range 0-7.
- IO_WAIT, 2, extra ACCESS cycles for region IO (0xC000-0xFFFF); range 0-7.

Ports:
- clk  in  1  single clock; everything is rising-edge.
- reset  in  1  asynchronous, active-high.
- req_valid  in  3  per-requester request; bit0 fetch, bit1 data, bit2 dma.
- req_write  in  3  per-requester 1=write, 0=read.
- req_addr  in  48  requester i address at [16i+15:16i].
- req_wdata  in  24  requester i write data at [8i+7:8i].
- req_ready  out  3  one-hot accept strobe.
- rsp_valid  out  3  one-hot completion strobe, one cycle.
- rsp_rdata  out  8  read data, valid while any rsp_valid bit is set.
- rsp_err  out  1  error flag, qualified by rsp_valid.
- address  out  16  bus address.
- read  out  1  bus read strobe.
- write  out  1  bus write strobe.
- dataOut  out  8  bus write data.
- dataIn  in  8  bus read data.
- cs_rom, cs_ram, cs_io  out  1 each  region chip selects.

Behaviour:
- Reset (async) values:
  - State IDLE.
  - All outputs 0.
  - Round-robin pointer last=2, so requester 0 has first priority.
  - An in-flight transaction is dropped: no rsp_valid is ever issued for it.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - grant g = first requester with req_valid set, scanning (last+1) mod 3 upward.
  - req_ready[g]=1 combinationally, in IDLE only.
  - On that edge: latch addr, wdata, write and g; set last=g; load wait counter from the region of the latched address; go to ACCESS.
  - No valid requests -> stay in IDLE, req_ready=0.
- ACCESS:
  - Drive address = latched address and the region's cs_*.
  - Reads: read=1. Writes: write=1, dataOut = latched wdata.
  - Outputs stay stable for 1+WAIT cycles.
  - On the final cycle (counter==0): sample dataIn into the rsp_rdata register, then go to RESP. Otherwise decrement the counter.
- RESP:
  - Bus outputs and cs_* return to 0.
  - rsp_valid[g]=1 for exactly one cycle.
  - Go to IDLE; a new grant is possible in the following cycle.
- Latency: accept edge T; ACCESS occupies cycles T+1..T+1+W; rsp_valid at T+2+W. Minimum issue interval 3+W cycles.
- Region decode from address[15:14]: 00 ROM, 01/10 RAM, 11 IO.
- Write to ROM:
  - Goes through ACCESS with ROM_WAIT, but write stays 0 and cs_rom stays 0.
  - rsp_err=1, rsp_rdata=0.
- Writes in general: rsp_rdata=0. All other transactions have rsp_err=0.
- Requester contract:
  - req_valid, req_addr, req_wdata and req_write must hold until req_ready.
  - Deasserting req_valid before grant is legal and yields no transaction.
  - Changes after accept are ignored (latched values are used).
- Simultaneous requests: exactly one is granted per IDLE cycle; the losers keep waiting.
- Fairness: with all three valid continuously, grant order is 0,1,2,0,...
- A requester that holds req_valid is served within 2 other transactions.
- No combinational path from dataIn to any output; rsp_rdata is registered.

Decomposition:
- Shared package bus_pkg holds:
  - region_t enum (REG_ROM, REG_RAM, REG_IO).
  - arb_state_t enum (ST_IDLE, ST_ACCESS, ST_RESP).
  - Requester index constants REQ_FETCH=0, REQ_DATA=1, REQ_DMA=2.
  - Region base constants.
  - IO_NONE/IO_READ/IO_WRITE encodings.
- One sub-module: rr_arbiter3.
  - Combinational 3-way round-robin grant from req_valid and last.
  - Outputs one-hot grant plus a "any" flag.

Test Plan:
1. Reset released, only req_valid[0]=1, addr 0x0010 read, ROM returns 0xE0 -> req_ready=001 at T; read=1, cs_rom=1, address=0x0010 at T+1; rsp_valid=001, rsp_rdata=0xE0 at T+2.
2. Requester 1 writes 0x5A to 0x4100 -> write=1, cs_ram=1, dataOut=0x5A for 1 cycle; rsp_valid=010, rsp_rdata=0x00, rsp_err=0.
3. All three valid continuously -> grants 001,010,100,001, each spaced 3 cycles apart (zero-wait regions).
4. Requester 2 reads 0xC003 with IO_WAIT=2 -> read/cs_io high for 3 cycles; rsp_valid=100 three cycles after the accept edge plus one.
5. Requester 0 writes to 0x0005 -> write=0 and cs_rom=0 throughout; rsp_valid=001 with rsp_err=1.
6. Reset asserted mid-ACCESS (IO_WAIT=2, cycle 2) -> read/cs_io/address drop to 0 immediately, no rsp_valid; after release, requester 0 is granted first.
